// File: rtl/reciprocal_lut_builder.sv
// reciprocal_lut_builder: generates the slope (m) and intercept (b) tables of
// the reciprocal interpolator at run time. A bit-serial restoring divider
// produces B(k) = floor(NUMERATOR*2^16 / (k*2^NB)) one quotient bit per cycle.
// Each table entry is streamed out through a valid/ready write port.
// Optional build macro: RECIPROCAL_LUT_ROUND_EN (round-to-nearest quotients,
// one extra divider iteration per entry).
//
// Write port handshake: an entry transfers on a cycle where wr_valid_o and
// wr_ready_i are both high. Once wr_valid_o rises it stays high, and wr_addr_o,
// wr_m_o and wr_b_o hold their values, until that transfer happens.
module reciprocal_lut_builder #(
   parameter int NB_BITS_PER_SUBDIVISION = 5,
   parameter int NUMERATOR               = 256
) (
   input  logic                                clk,
   input  logic                                reset_ni,
   input  logic                                start_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic                                wr_valid_o,
   input  logic                                wr_ready_i,
   output logic [15-NB_BITS_PER_SUBDIVISION:0] wr_addr_o,
   output logic [15:0]                         wr_m_o,
   output logic [23:0]                         wr_b_o,
   output logic [2:0]                          state_o
);

   localparam int AW = 16 - NB_BITS_PER_SUBDIVISION;  // entry index width
   localparam int KW = AW + 1;                        // k runs 1..N
   localparam int N  = 1 << AW;                       // number of entries

   // The 2^NB factor of the divisor is folded into the dividend. NUMERATOR*2^16
   // is a multiple of 2^NB, so this shift is exact and the divisor becomes k.
`ifdef RECIPROCAL_LUT_ROUND_EN
   localparam logic [31:0] DIVIDEND = 32'(NUMERATOR) << (17 - NB_BITS_PER_SUBDIVISION);
`else
   localparam logic [31:0] DIVIDEND = 32'(NUMERATOR) << (16 - NB_BITS_PER_SUBDIVISION);
`endif
   localparam int DQ = $clog2(DIVIDEND + 1);  // quotient bits = divider iterations
   localparam int CW = $clog2(DQ);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR0  = 3'd1,
      S_DIV  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          state;
   logic [KW-1:0]   k;        // divisor of the quotient in progress
   logic [AW-1:0]   rem;      // partial remainder, always below k
   logic [DQ-2:0]   quo;      // quotient bits collected so far
   logic [CW-1:0]   bit_cnt;  // dividend bit consumed this cycle
   logic [31:0]     b_prev;   // B(k-1)
   logic [31:0]     b_cur;    // B(k)

   logic [KW-1:0]   rem_sh;
   logic            q_bit;
   logic [DQ-1:0]   quo_nxt;
   logic [31:0]     b_new;
   logic [15:0]     m_new;

   // One restoring-division step, plus the finished B and slope when it ends.
   always_comb begin
      rem_sh  = {rem, DIVIDEND[bit_cnt]};
      q_bit   = (rem_sh >= k);
      quo_nxt = {quo, q_bit};
`ifdef RECIPROCAL_LUT_ROUND_EN
      b_new   = (32'(quo_nxt) + 32'd1) >> 1;
`else
      b_new   = 32'(quo_nxt);
`endif
      // Slope is the arithmetic-shifted difference; only its low half is sent,
      // the upper half is pure sign extension.
      m_new   = 16'($signed(b_new - b_prev) >>> NB_BITS_PER_SUBDIVISION);
   end

   // Build sequencer: entry 0, then one division per entry and a write.
   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         state      <= S_IDLE;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         wr_valid_o <= 1'b0;
         wr_addr_o  <= '0;
         wr_m_o     <= '0;
         wr_b_o     <= '0;
         k          <= '0;
         rem        <= '0;
         quo        <= '0;
         bit_cnt    <= '0;
         b_prev     <= '0;
         b_cur      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  state      <= S_WR0;
                  busy_o     <= 1'b1;
                  wr_valid_o <= 1'b1;
                  wr_addr_o  <= '0;
                  wr_m_o     <= 16'hFFFF;
                  wr_b_o     <= 24'hFFFFFF;
               end
            end

            S_WR0: begin
               if (wr_ready_i) begin
                  wr_valid_o <= 1'b0;
                  k          <= KW'(1);
                  rem        <= '0;
                  quo        <= '0;
                  bit_cnt    <= CW'(DQ - 1);
                  state      <= S_DIV;
               end
            end

            S_DIV: begin
               rem     <= AW'(q_bit ? rem_sh - k : rem_sh);
               quo     <= quo_nxt[DQ-2:0];
               bit_cnt <= bit_cnt - 1'b1;
               if (bit_cnt == '0) begin
                  rem     <= '0;
                  quo     <= '0;
                  bit_cnt <= CW'(DQ - 1);
                  if (k == KW'(1)) begin
                     // B(1) alone cannot form an entry; go straight on to B(2).
                     b_prev <= b_new;
                     k      <= KW'(2);
                  end else begin
                     b_cur      <= b_new;
                     wr_valid_o <= 1'b1;
                     wr_addr_o  <= AW'(k - 1'b1);
                     wr_m_o     <= m_new;
                     wr_b_o     <= b_prev[23:0];
                     state      <= S_WR;
                  end
               end
            end

            S_WR: begin
               if (wr_ready_i) begin
                  wr_valid_o <= 1'b0;
                  if (k == KW'(N)) begin
                     done_o <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     b_prev <= b_cur;
                     k      <= k + 1'b1;
                     state  <= S_DIV;
                  end
               end
            end

            S_DONE: begin
               done_o <= 1'b0;
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign state_o = state;

endmodule
